// File: rtl/gpio_loopback_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | gpio_loopback_seq : Wishbone master running a walking-one/zero GPIO loopback test
// | Revision 1.0
// +-----------------------------------------------------------------------------
module gpio_loopback_seq #(
   parameter int WORDS   = 3,
   parameter int TIMEOUT = 255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        start_i,
   input  logic        invert_i,
   input  logic        abort_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        pass_o,
   output logic [1:0]  err_code_o,
   output logic [7:0]  fail_bit_o,
   output logic [15:0] fail_dat_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [1:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [15:0] wbm_dat_o,
   input  logic [15:0] wbm_dat_i,
   input  logic        wbm_ack_i
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      OE_ON  = 3'd1,
      WR_OUT = 3'd2,
      RD_IN  = 3'd3,
      CHECK  = 3'd4,
      OE_OFF = 3'd5,
      FINISH = 3'd6
   } state_t;

   localparam logic [3:0]  C_LAST_W   = 4'(WORDS - 1);
   localparam logic [7:0]  C_TMO_LAST = 8'(TIMEOUT - 1);
   localparam logic [31:0] C_OUT_BASE = 32'h0000_0020;
   localparam logic [31:0] C_OE_BASE  = 32'h0000_0040;

   localparam logic [1:0] C_ERR_NONE  = 2'd0;
   localparam logic [1:0] C_ERR_MISM  = 2'd1;
   localparam logic [1:0] C_ERR_TMO   = 2'd2;
   localparam logic [1:0] C_ERR_ABORT = 2'd3;

   state_t      state_q, state_d;
   logic [3:0]  w_q, w_d;
   logic [3:0]  k_q, k_d;
   logic        inv_q, inv_d;
   logic        abort_q, abort_d;
   logic        cyc_q, cyc_d;
   logic        we_q, we_d;
   logic [31:0] adr_q, adr_d;
   logic [15:0] dat_q, dat_d;
   logic [7:0]  tmo_q, tmo_d;
   logic [15:0] rdat_q, rdat_d;
   logic        pass_q, pass_d;
   logic [1:0]  err_q, err_d;
   logic [7:0]  fbit_q, fbit_d;
   logic [15:0] fdat_q, fdat_d;
   logic [1:0]  sel_q;

   logic [15:0] w_pat;
   logic [31:0] w_off;
   logic        w_in_run;
   logic        w_abort;
   logic        w_bus_we;
   logic [31:0] w_bus_adr;
   logic [15:0] w_bus_dat;

   assign w_pat    = (16'h0001 << k_q) ^ {16{inv_q}};
   assign w_off    = {27'd0, w_q, 1'b0};
   assign w_in_run = (state_q == OE_ON) || (state_q == WR_OUT) ||
                     (state_q == RD_IN) || (state_q == CHECK);
   assign w_abort  = abort_i | abort_q;

   always_comb begin
      w_bus_we  = 1'b1;
      w_bus_adr = C_OE_BASE + w_off;
      w_bus_dat = 16'h0000;
      case (state_q)
         OE_ON:   w_bus_dat = 16'hFFFF;
         WR_OUT: begin
            w_bus_adr = C_OUT_BASE + w_off;
            w_bus_dat = w_pat;
         end
         RD_IN: begin
            w_bus_we  = 1'b0;
            w_bus_adr = w_off;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      w_d     = w_q;
      k_d     = k_q;
      inv_d   = inv_q;
      abort_d = abort_q;
      cyc_d   = cyc_q;
      we_d    = we_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      tmo_d   = tmo_q;
      rdat_d  = rdat_q;
      pass_d  = pass_q;
      err_d   = err_q;
      fbit_d  = fbit_q;
      fdat_d  = fdat_q;

      if (w_in_run && abort_i) abort_d = 1'b1;
      if (cyc_q) tmo_d = tmo_q + 8'd1;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               pass_d  = 1'b0;
               err_d   = C_ERR_NONE;
               fbit_d  = 8'd0;
               fdat_d  = 16'd0;
               inv_d   = invert_i;
               w_d     = 4'd0;
               k_d     = 4'd0;
               abort_d = 1'b0;
               state_d = OE_ON;
            end
         end

         CHECK: begin
            // A mismatch found this cycle outranks an abort arriving alongside it.
            if (rdat_q != w_pat) begin
               err_d   = C_ERR_MISM;
               fbit_d  = {w_q, k_q};
               fdat_d  = rdat_q;
               w_d     = 4'd0;
               abort_d = 1'b0;
               state_d = OE_OFF;
            end else if (w_abort) begin
               if (err_q == C_ERR_NONE) err_d = C_ERR_ABORT;
               w_d     = 4'd0;
               abort_d = 1'b0;
               state_d = OE_OFF;
            end else if (k_q == 4'd15) begin
               k_d = 4'd0;
               if (w_q == C_LAST_W) begin
                  w_d     = 4'd0;
                  state_d = OE_OFF;
               end else begin
                  w_d     = w_q + 4'd1;
                  state_d = WR_OUT;
               end
            end else begin
               k_d     = k_q + 4'd1;
               state_d = WR_OUT;
            end
         end

         FINISH: begin
            abort_d = 1'b0;
            state_d = IDLE;
         end

         default: begin
            if (!cyc_q) begin
               if (w_in_run && w_abort) begin
                  if (err_q == C_ERR_NONE) err_d = C_ERR_ABORT;
                  w_d     = 4'd0;
                  abort_d = 1'b0;
                  state_d = OE_OFF;
               end else begin
                  cyc_d = 1'b1;
                  we_d  = w_bus_we;
                  adr_d = w_bus_adr;
                  dat_d = w_bus_dat;
                  tmo_d = 8'd0;
               end
            end else if (wbm_ack_i) begin
               cyc_d = 1'b0;
               if (state_q == RD_IN) rdat_d = wbm_dat_i;
               if (w_in_run && w_abort) begin
                  if (err_q == C_ERR_NONE) err_d = C_ERR_ABORT;
                  w_d     = 4'd0;
                  abort_d = 1'b0;
                  state_d = OE_OFF;
               end else begin
                  case (state_q)
                     OE_ON: begin
                        if (w_q == C_LAST_W) begin
                           w_d     = 4'd0;
                           state_d = WR_OUT;
                        end else begin
                           w_d = w_q + 4'd1;
                        end
                     end
                     WR_OUT:  state_d = RD_IN;
                     RD_IN:   state_d = CHECK;
                     default: begin
                        if (w_q == C_LAST_W) begin
                           pass_d  = (err_q == C_ERR_NONE);
                           state_d = FINISH;
                        end else begin
                           w_d = w_q + 4'd1;
                        end
                     end
                  endcase
               end
            end else if (tmo_q == C_TMO_LAST) begin
               // Dead slave: output-enable cleanup would only time out again.
               cyc_d   = 1'b0;
               err_d   = C_ERR_TMO;
               pass_d  = 1'b0;
               state_d = FINISH;
            end
         end
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= IDLE;
         w_q     <= 4'd0;
         k_q     <= 4'd0;
         inv_q   <= 1'b0;
         abort_q <= 1'b0;
         cyc_q   <= 1'b0;
         we_q    <= 1'b0;
         adr_q   <= 32'd0;
         dat_q   <= 16'd0;
         tmo_q   <= 8'd0;
         rdat_q  <= 16'd0;
         pass_q  <= 1'b0;
         err_q   <= C_ERR_NONE;
         fbit_q  <= 8'd0;
         fdat_q  <= 16'd0;
         sel_q   <= 2'b00;
      end else begin
         state_q <= state_d;
         w_q     <= w_d;
         k_q     <= k_d;
         inv_q   <= inv_d;
         abort_q <= abort_d;
         cyc_q   <= cyc_d;
         we_q    <= we_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         tmo_q   <= tmo_d;
         rdat_q  <= rdat_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         fbit_q  <= fbit_d;
         fdat_q  <= fdat_d;
         sel_q   <= 2'b11;
      end
   end

   assign busy_o     = (state_q != IDLE);
   assign done_o     = (state_q == FINISH);
   assign pass_o     = pass_q;
   assign err_code_o = err_q;
   assign fail_bit_o = fbit_q;
   assign fail_dat_o = fdat_q;
   assign wbm_cyc_o  = cyc_q;
   assign wbm_stb_o  = cyc_q;
   assign wbm_we_o   = we_q;
   assign wbm_sel_o  = sel_q;
   assign wbm_adr_o  = adr_q;
   assign wbm_dat_o  = dat_q;

endmodule
`default_nettype wire

// File: tb/tb_gpio_loopback_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | tb_gpio_loopback_seq : GPIO loopback slave model and bus-cycle scoreboard
// | Revision 1.0
// +-----------------------------------------------------------------------------
module tb_gpio_loopback_seq;

   localparam int W   = 3;
   localparam int TMO = 255;

   typedef struct packed {
      logic [31:0] adr;
      logic        we;
      logic [15:0] dat;
   } bus_t;

   logic        clk = 1'b0;
   logic        rst, start, inv, abort_s;
   logic        busy, done, pass;
   logic [1:0]  err;
   logic [7:0]  fbit;
   logic [15:0] fdat;
   logic        cyc, stb, we;
   logic [1:0]  sel;
   logic [31:0] adr;
   logic [15:0] dat;
   logic        ack_r = 1'b0;
   logic [15:0] rdat_r = 16'h0000;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   gpio_loopback_seq #(.WORDS(W), .TIMEOUT(TMO)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .invert_i(inv), .abort_i(abort_s),
      .busy_o(busy), .done_o(done), .pass_o(pass), .err_code_o(err),
      .fail_bit_o(fbit), .fail_dat_o(fdat),
      .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
      .wbm_adr_o(adr), .wbm_dat_o(dat), .wbm_dat_i(rdat_r), .wbm_ack_i(ack_r)
   );

   // Loopback slave: input word = driven output bits, then stuck-at faults applied.
   logic [15:0]  g_out [16];
   logic [15:0]  g_oe  [16];
   logic [255:0] s0, s1;
   int           withhold_n;
   int           slv_cnt = 0;
   int           this_num;
   logic         cyc_prev_s = 1'b0;

   always @(posedge clk) begin
      this_num = (cyc && !cyc_prev_s) ? slv_cnt + 1 : slv_cnt;
      slv_cnt    <= this_num;
      cyc_prev_s <= cyc;
      ack_r      <= 1'b0;
      if (cyc && stb && !ack_r && this_num != withhold_n) begin
         ack_r <= 1'b1;
         if (we) begin
            if (adr[7:0] >= 8'h40)      g_oe[adr[4:1]]  <= dat;
            else if (adr[7:0] >= 8'h20) g_out[adr[4:1]] <= dat;
         end else begin
            rdat_r <= ((g_out[adr[4:1]] & g_oe[adr[4:1]]) | s1[int'(adr[4:1])*16 +: 16])
                      & ~s0[int'(adr[4:1])*16 +: 16];
         end
      end
   end

   bus_t exp_q[$];
   int   r_nbus, r_len;
   logic r_done, r_pass;
   logic [1:0]  r_err;
   logic [7:0]  r_fbit;
   logic [15:0] r_fdat;

   function automatic bus_t mk(input int a, input logic w_e, input logic [15:0] d);
      bus_t b;
      b.adr = a[31:0];
      b.we  = w_e;
      b.dat = d;
      return b;
   endfunction

   task automatic push_oe_off();
      for (int w = 0; w < W; w++) exp_q.push_back(mk(32'h40 + 2*w, 1'b1, 16'h0000));
   endtask

   task automatic build_exp(input logic inv_m);
      logic [15:0] p, rd;
      bit mism = 0;
      exp_q.delete();
      for (int w = 0; w < W; w++) exp_q.push_back(mk(32'h40 + 2*w, 1'b1, 16'hFFFF));
      for (int w = 0; w < W && !mism; w++) begin
         for (int k = 0; k < 16 && !mism; k++) begin
            p = (16'h0001 << k) ^ (inv_m ? 16'hFFFF : 16'h0000);
            exp_q.push_back(mk(32'h20 + 2*w, 1'b1, p));
            exp_q.push_back(mk(2*w, 1'b0, 16'h0000));
            rd = (p | s1[w*16 +: 16]) & ~s0[w*16 +: 16];
            if (rd !== p) mism = 1;
         end
      end
      push_oe_off();
   endtask

   // Pulses start, then monitors every bus cycle against the scoreboard until done.
   task automatic run_seq(input int budget, input int abort_at, input int start_at, input int probe);
      logic prev = 1'b0;
      bit   seen = 0, fin = 0;
      bus_t e;
      r_nbus = 0; r_len = 0; r_done = 0; r_pass = 0; r_err = 0; r_fbit = 0; r_fdat = 0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int c = 0; c < budget && !fin; c++) begin
         start   = 1'b0;
         abort_s = 1'b0;
         if (seen) begin
            fin = 1;
            tests++;
            if (done !== 1'b0 || busy !== 1'b0) begin
               fails++;
               $display("FAIL done_pulse: done=%b busy=%b one cycle after done, required 0 0", done, busy);
            end
         end else begin
            if (cyc && !prev) begin
               r_nbus++;
               tests++;
               if (exp_q.size() == 0) begin
                  fails++;
                  $display("FAIL bus%0d: unexpected cycle adr=%h we=%b dat=%h", r_nbus, adr, we, dat);
               end else begin
                  e = exp_q.pop_front();
                  if (adr !== e.adr || we !== e.we || (e.we && dat !== e.dat) ||
                      stb !== 1'b1 || sel !== 2'b11) begin
                     fails++;
                     $display("FAIL bus%0d: adr=%h we=%b dat=%h stb=%b sel=%b, required adr=%h we=%b dat=%h stb=1 sel=11",
                              r_nbus, adr, we, dat, stb, sel, e.adr, e.we, e.dat);
                  end
               end
               if (r_nbus == abort_at) abort_s = 1'b1;
               if (r_nbus == start_at) start = 1'b1;
            end
            if (cyc && r_nbus == probe) r_len++;
            if (done) begin
               seen = 1; r_done = 1; r_pass = pass; r_err = err; r_fbit = fbit; r_fdat = fdat;
            end
            prev = cyc;
         end
         @(negedge clk);
      end
      start = 1'b0;
      abort_s = 1'b0;
      tests++;
      if (!fin) begin
         fails++;
         $display("FAIL run_budget: no done within %0d cycles, required done", budget);
      end
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL sb_drain: %0d expected bus cycles never issued, required 0", exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; inv = 1'b0; abort_s = 1'b0;
      s0 = '0; s1 = '0; withhold_n = -1;
      repeat (2) @(negedge clk);
      tests++;
      if ({busy, done, pass, err, fbit, fdat, cyc, stb, we, sel, adr, dat} !== 82'd0) begin
         fails++;
         $display("FAIL reset_outputs: busy=%b done=%b pass=%b err=%0d fbit=%0d fdat=%h cyc=%b stb=%b we=%b sel=%b adr=%h dat=%h, required all 0",
                  busy, done, pass, err, fbit, fdat, cyc, stb, we, sel, adr, dat);
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      tests++;
      if (busy !== 1'b0 || cyc !== 1'b0) begin
         fails++;
         $display("FAIL reset_idle: busy=%b cyc=%b without start, required 0 0", busy, cyc);
      end
   endtask

   task automatic test_pass_run();
      s0 = '0; s1 = '0; inv = 1'b0;
      build_exp(1'b0);
      run_seq(2000, -1, -1, -1);
      tests++;
      if (r_nbus !== 102 || r_pass !== 1'b1 || r_err !== 2'd0) begin
         fails++;
         $display("FAIL pass_run: nbus=%0d pass=%b err=%0d, required 102 1 0", r_nbus, r_pass, r_err);
      end
      tests++;
      if ({g_oe[0], g_oe[1], g_oe[2]} !== 48'd0) begin
         fails++;
         $display("FAIL pass_oe_clear: oe=%h %h %h, required 0000 0000 0000", g_oe[0], g_oe[1], g_oe[2]);
      end
   endtask

   task automatic test_stuck0_bit20();
      s0 = '0; s1 = '0; s0[20] = 1'b1; inv = 1'b0;
      build_exp(1'b0);
      run_seq(2000, -1, -1, -1);
      tests++;
      if (r_err !== 2'd1 || r_fbit !== 8'd20 || r_fdat !== 16'h0000 || r_pass !== 1'b0) begin
         fails++;
         $display("FAIL stuck0_bit20: err=%0d fbit=%0d fdat=%h pass=%b, required 1 20 0000 0",
                  r_err, r_fbit, r_fdat, r_pass);
      end
      tests++;
      if ({g_oe[0], g_oe[1], g_oe[2]} !== 48'd0) begin
         fails++;
         $display("FAIL stuck0_oe_clear: oe=%h %h %h, required all 0000", g_oe[0], g_oe[1], g_oe[2]);
      end
   endtask

   task automatic test_invert_stuck1_bit5();
      s0 = '0; s1 = '0; s1[5] = 1'b1; inv = 1'b1;
      build_exp(1'b1);
      run_seq(2000, -1, -1, -1);
      tests++;
      if (r_err !== 2'd1 || r_fbit !== 8'd5 || r_fdat !== 16'hFFFF) begin
         fails++;
         $display("FAIL invert_stuck1_bit5: err=%0d fbit=%0d fdat=%h, required 1 5 ffff", r_err, r_fbit, r_fdat);
      end
      inv = 1'b0;
   endtask

   task automatic test_timeout();
      s0 = '0; s1 = '0; inv = 1'b0;
      build_exp(1'b0);
      while (exp_q.size() > 10) void'(exp_q.pop_back());
      withhold_n = slv_cnt + 10;
      run_seq(2000, -1, -1, 10);
      withhold_n = -1;
      tests++;
      if (r_len !== TMO) begin
         fails++;
         $display("FAIL timeout_len: cyc high %0d cycles, required %0d", r_len, TMO);
      end
      tests++;
      if (r_err !== 2'd2 || r_pass !== 1'b0 || r_nbus !== 10) begin
         fails++;
         $display("FAIL timeout_result: err=%0d pass=%b nbus=%0d, required 2 0 10", r_err, r_pass, r_nbus);
      end
      tests++;
      if (g_oe[0] !== 16'hFFFF) begin
         fail_oe: begin
            fails++;
            $display("FAIL timeout_no_cleanup: oe0=%h, required ffff", g_oe[0]);
         end
      end
   endtask

   task automatic test_abort();
      s0 = '0; s1 = '0; inv = 1'b0;
      build_exp(1'b0);
      while (exp_q.size() > 5) void'(exp_q.pop_back());
      push_oe_off();
      run_seq(2000, 5, 2, -1);
      tests++;
      if (r_err !== 2'd3 || r_pass !== 1'b0 || r_nbus !== 8) begin
         fails++;
         $display("FAIL abort_result: err=%0d pass=%b nbus=%0d, required 3 0 8", r_err, r_pass, r_nbus);
      end
      repeat (10) @(negedge clk);
      tests++;
      if (busy !== 1'b0 || cyc !== 1'b0) begin
         fails++;
         $display("FAIL abort_idle: busy=%b cyc=%b after run, required 0 0", busy, cyc);
      end
   endtask

   task automatic test_reset_midcycle();
      int c;
      s0 = '0; s1 = '0; inv = 1'b0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (c = 0; c < 50 && !(stb === 1'b1 && adr === 32'h42); c++) @(negedge clk);
      tests++;
      if (c >= 50) begin
         fails++;
         $display("FAIL midreset_wait: stb for adr 42 not seen in 50 cycles, required seen");
      end
      rst = 1'b1;
      @(negedge clk);
      tests++;
      if ({busy, done, pass, err, fbit, fdat, cyc, stb, we, sel, adr, dat} !== 82'd0) begin
         fails++;
         $display("FAIL midreset_outputs: busy=%b cyc=%b stb=%b we=%b sel=%b adr=%h dat=%h err=%0d, required all 0",
                  busy, cyc, stb, we, sel, adr, dat, err);
      end
      rst = 1'b0;
      repeat (5) @(negedge clk);
      tests++;
      if (g_oe[0] !== 16'hFFFF || cyc !== 1'b0) begin
         fails++;
         $display("FAIL midreset_no_cleanup: oe0=%h cyc=%b, required ffff 0", g_oe[0], cyc);
      end
      build_exp(1'b0);
      run_seq(2000, -1, -1, -1);
      tests++;
      if (r_nbus !== 102 || r_pass !== 1'b1 || r_err !== 2'd0) begin
         fails++;
         $display("FAIL midreset_rerun: nbus=%0d pass=%b err=%0d, required 102 1 0", r_nbus, r_pass, r_err);
      end
   endtask

   initial begin
      test_reset();
      test_pass_run();
      test_stuck0_bit20();
      test_invert_stuck1_bit5();
      test_timeout();
      test_abort();
      test_reset_midcycle();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
